// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// Packets are kept atomic by locking the grant until the byte flagged `last` finishes.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ACCEPT_TIMEOUT = 16
) (
    input  logic                  txclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic                  ld_tx_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_enable,
    input  logic                  tx_empty,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [15:0]           byte_count,
    output logic                  err
);

    localparam int unsigned TO_W = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACCEPT,
        WAIT_EMPTY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              lock_valid;
    logic              lock_id;
    logic              rr_ptr;
    logic              last_q;
    logic [TO_W-1:0]   to_cnt;
    logic              sel_valid;
    logic              sel_id;
    logic              accept;
    logic              byte_done;
    logic              byte_drop;

    // A held lock restricts eligibility to its owner; otherwise the pointer breaks ties.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        if (lock_valid) begin
            sel_id    = lock_id;
            sel_valid = lock_id ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            sel_id    = rr_ptr;
            sel_valid = 1'b1;
        end else if (req0_valid) begin
            sel_valid = 1'b1;
        end else if (req1_valid) begin
            sel_id    = 1'b1;
            sel_valid = 1'b1;
        end
        accept = reset && (state == IDLE) && enable && tx_empty && sel_valid;
    end

    assign req0_ready = accept && !sel_id;
    assign req1_ready = accept && sel_id;
    assign ld_tx_data = (state == LOAD);
    assign busy       = (state != IDLE);
    assign grant      = lock_valid ? (lock_id ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        byte_drop = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: state_nxt = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (!tx_empty) begin
                    state_nxt = WAIT_EMPTY;
                end else if (to_cnt == TO_W'(ACCEPT_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    byte_drop = 1'b1;
                end
            end
            WAIT_EMPTY: begin
                if (tx_empty) begin
                    state_nxt = IDLE;
                    byte_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx_data    <= '0;
            tx_enable  <= 1'b0;
            last_q     <= 1'b0;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            rr_ptr     <= 1'b0;
            to_cnt     <= '0;
            byte_count <= '0;
            err        <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_enable <= enable;
            if (accept) begin
                tx_data    <= sel_id ? req1_data : req0_data;
                last_q     <= sel_id ? req1_last : req0_last;
                lock_valid <= 1'b1;
                lock_id    <= sel_id;
            end
            if (state == LOAD) begin
                to_cnt <= '0;
            end else if (state == WAIT_ACCEPT) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (byte_done) byte_count <= byte_count + 16'd1;
            if (byte_drop) err <= 1'b1;
            // A dropped byte releases the packet exactly as a completed one would.
            if ((byte_done || byte_drop) && last_q) begin
                lock_valid <= 1'b0;
                rr_ptr     <= ~lock_id;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: ready truth table, directed
// multi-cycle sequences, and a randomized packet run against a stream model.
module tb_uart_tx_arbiter;

    logic        txclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [7:0]  req0_data, req1_data, tx_data;
    logic        ld_tx_data, tx_enable, tx_empty, busy, err;
    logic [1:0]  grant;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 txclk = ~txclk;

    uart_tx_arbiter #(.DATA_WIDTH(8), .ACCEPT_TIMEOUT(16)) dut (
        .txclk(txclk), .reset(reset), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .ld_tx_data(ld_tx_data), .tx_data(tx_data), .tx_enable(tx_enable), .tx_empty(tx_empty),
        .grant(grant), .busy(busy), .byte_count(byte_count), .err(err)
    );

    typedef struct {
        bit en, te, v0, v1, r0, r1;
    } vec_t;

    typedef struct {
        bit [7:0] d;
        bit       last;
    } byte_t;

    typedef struct {
        bit       id;
        bit [7:0] d;
    } exp_t;

    function automatic vec_t mkvec(input bit [5:0] b);
        vec_t v;
        {v.en, v.te, v.v0, v.v1, v.r0, v.r1} = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge txclk);
        @(negedge txclk);
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        tx_empty   = 1'b1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        idle_inputs();
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld"},     ld_tx_data, 0);
        chk({tag, "_data"},   tx_data, 0);
        chk({tag, "_txen"},   tx_enable, 0);
        chk({tag, "_grant"},  grant, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_count"},  byte_count, 0);
        chk({tag, "_err"},    err, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
    endtask

    // Waits (bounded) for a load strobe, captures it, then plays a UART that
    // goes busy for one cycle and returns idle. Returns at a negedge in IDLE.
    task automatic serve_byte(output logic [1:0] g, output logic [7:0] d);
        bit seen = 1'b0;
        g = '0;
        d = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ld_tx_data) begin
                seen = 1'b1;
                g = grant;
                d = tx_data;
            end else begin
                tick();
            end
        end
        chk("serve_load_seen", seen, 1);
        if (!seen) return;
        tx_empty = 1'b0;
        tick();
        tick();
        tx_empty = 1'b1;
        tick();
    endtask

    vec_t        vt[8];
    byte_t       q0[$], q1[$];
    exp_t        expq[$];
    logic [1:0]  g;
    logic [7:0]  d;

    initial begin
        vt[0] = mkvec(6'b11_10_10);
        vt[1] = mkvec(6'b11_01_01);
        vt[2] = mkvec(6'b11_11_10);
        vt[3] = mkvec(6'b01_11_00);
        vt[4] = mkvec(6'b10_11_00);
        vt[5] = mkvec(6'b10_10_00);
        vt[6] = mkvec(6'b00_01_00);
        vt[7] = mkvec(6'b11_00_00);

        // Reset state, with requests pending and enable high.
        reset = 1'b0;
        idle_inputs();
        enable = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge txclk);
        tick();
        chk_all_zero("reset");

        // IDLE ready truth table (pointer at requester 0, no lock).
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enable     = vt[i].en;
            tx_empty   = vt[i].te;
            req0_valid = vt[i].v0;
            req1_valid = vt[i].v1;
            #1;
            chk($sformatf("table%0d_ready0", i), req0_ready, vt[i].r0);
            chk($sformatf("table%0d_ready1", i), req1_ready, vt[i].r1);
            idle_inputs();
            enable = 1'b1;
            tick();
        end
        chk("table_no_accept", busy, 0);

        // Single byte.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        tick();
        chk("single_ld", ld_tx_data, 1);
        chk("single_data", tx_data, 8'h55);
        chk("single_grant_load", grant, 2'b01);
        chk("single_ready0_load", req0_ready, 0);
        req0_valid = 1'b0;
        tx_empty = 1'b0;
        tick();
        chk("single_ld_once", ld_tx_data, 0);
        tick();
        chk("single_grant_wait", grant, 2'b01);
        chk("single_busy_wait", busy, 1);
        tx_empty = 1'b1;
        tick();
        chk("single_count", byte_count, 1);
        chk("single_grant_done", grant, 2'b00);
        chk("single_busy_done", busy, 0);

        // Contention from reset: round-robin 0, 1, 0.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hB1; req1_last = 1'b1;
        serve_byte(g, d);
        chk("rr_grant0", g, 2'b01);
        chk("rr_data0", d, 8'hA0);
        serve_byte(g, d);
        chk("rr_grant1", g, 2'b10);
        chk("rr_data1", d, 8'hB1);
        serve_byte(g, d);
        idle_inputs();
        chk("rr_grant2", g, 2'b01);
        chk("rr_count", byte_count, 3);

        // Packet lock: req1 waits out a three-byte req0 packet.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h10; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hEE; req1_last = 1'b1;
        #1;
        chk("lock_first_ready0", req0_ready, 1);
        chk("lock_first_ready1", req1_ready, 0);
        for (int b = 0; b < 3; b++) begin
            serve_byte(g, d);
            chk($sformatf("lock_grant%0d", b), g, 2'b01);
            chk($sformatf("lock_data%0d", b), d, 8'h10 + b);
            if (b < 2) begin
                req0_data = 8'h11 + 8'(b);
                req0_last = (b == 1);
                #1;
                chk($sformatf("lock_held_grant%0d", b), grant, 2'b01);
                chk($sformatf("lock_blocks_ready1_%0d", b), req1_ready, 0);
            end
        end
        req0_valid = 1'b0;
        #1;
        chk("lock_release_ready1", req1_ready, 1);
        serve_byte(g, d);
        idle_inputs();
        chk("lock_after_grant", g, 2'b10);
        chk("lock_after_data", d, 8'hEE);
        chk("lock_count", byte_count, 4);

        // Accept timeout with tx_empty stuck high.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b1;
        tick();
        chk("to_ld", ld_tx_data, 1);
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_busy_15", busy, 1);
        chk("to_err_15", err, 0);
        tick();
        chk("to_busy_16", busy, 0);
        chk("to_err_16", err, 1);
        chk("to_count", byte_count, 0);
        chk("to_grant", grant, 2'b00);
        req0_valid = 1'b1; req0_data = 8'h78; req0_last = 1'b1;
        serve_byte(g, d);
        req0_valid = 1'b0;
        chk("to_next_data", d, 8'h78);
        chk("to_err_sticky", err, 1);
        chk("to_next_count", byte_count, 1);

        // enable low during WAIT_EMPTY, then reset during WAIT_ACCEPT.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h21; req0_last = 1'b0;
        #1;
        chk("en_ready0", req0_ready, 1);
        tick();
        chk("en_ld", ld_tx_data, 1);
        req0_data = 8'h22;
        tx_empty = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        tx_empty = 1'b1;
        tick();
        chk("en_count", byte_count, 1);
        chk("en_busy", busy, 0);
        chk("en_lock_kept", grant, 2'b01);
        #1;
        chk("en_no_ready", req0_ready, 0);
        tick();
        tick();
        chk("en_still_idle", busy, 0);
        enable = 1'b1;
        #1;
        chk("en_ready_again", req0_ready, 1);
        tick();
        chk("en_second_data", tx_data, 8'h22);
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk_all_zero("abort_async");
        tick();
        chk_all_zero("abort_edge");
        reset = 1'b1;
        tick();
        chk("resume_idle", busy, 0);
        req0_valid = 1'b1; req0_data = 8'h33; req0_last = 1'b1;
        serve_byte(g, d);
        req0_valid = 1'b0;
        chk("resume_data", d, 8'h33);
        chk("resume_count", byte_count, 1);

        // Randomized packets: both requesters always offer their next byte.
        begin
            int  i0, i1, k, total;
            bit  turn, pending, prev_en, done;
            int  dly, bsy;
            exp_t e;
            do_reset();
            for (int r = 0; r < 2; r++) begin
                int np = $urandom_range(3, 6);
                for (int p = 0; p < np; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        byte_t x;
                        x.d = 8'($urandom);
                        x.last = (b == len - 1);
                        if (r == 0) q0.push_back(x); else q1.push_back(x);
                    end
                end
            end
            total = q0.size() + q1.size();
            // Expected stream: whole packets, alternating while both have work.
            i0 = 0; i1 = 0; turn = 1'b0;
            while (i0 < q0.size() || i1 < q1.size()) begin
                if (turn == 1'b0) k = (i0 < q0.size()) ? 0 : 1;
                else              k = (i1 < q1.size()) ? 1 : 0;
                forever begin
                    byte_t x;
                    x = (k == 0) ? q0[i0] : q1[i1];
                    if (k == 0) i0++; else i1++;
                    e.id = k[0];
                    e.d  = x.d;
                    expq.push_back(e);
                    if (x.last) break;
                end
                turn = ~k[0];
            end
            pending = 1'b0; dly = 0; bsy = 0; done = 1'b0;
            prev_en = enable;
            for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
                chk("rand_tx_enable", tx_enable, prev_en);
                if (ld_tx_data) begin
                    chk("rand_load_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("rand_data", tx_data, e.d);
                        chk("rand_grant", grant, e.id ? 2'b10 : 2'b01);
                    end
                    pending = 1'b1;
                    dly = $urandom_range(1, 4);
                    bsy = $urandom_range(1, 4);
                end else if (pending) begin
                    if (dly > 0) dly--;
                    else if (bsy > 1) bsy--;
                    else pending = 1'b0;
                end
                tx_empty = !(pending && dly == 0);
                enable = ($urandom_range(0, 3) != 0);
                prev_en = enable;
                req0_valid = (q0.size() > 0);
                if (req0_valid) begin req0_data = q0[0].d; req0_last = q0[0].last; end
                req1_valid = (q1.size() > 0);
                if (req1_valid) begin req1_data = q1[0].d; req1_last = q1[0].last; end
                #1;
                chk("rand_ready_only_idle", (req0_ready | req1_ready) & busy, 0);
                chk("rand_ready_onehot", req0_ready & req1_ready, 0);
                if (req0_valid && req0_ready) void'(q0.pop_front());
                if (req1_valid && req1_ready) void'(q1.pop_front());
                done = (expq.size() == 0) && (q0.size() == 0) && (q1.size() == 0) && !busy && !pending;
                if (!done) tick();
            end
            chk("rand_complete", done, 1);
            chk("rand_byte_count", byte_count, total);
            chk("rand_err_clear", err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
